// File: rtl/ahb_mtx_pkg.sv
// Shared AHB matrix encodings used by the input, decode and output/arbiter stages.
package ahb_mtx_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_PEND = 1'b1
  } in_state_e;

  // trans(2) + write(1) + size(3) + burst(3) + prot(4) + lock(1)
  localparam int unsigned ATTR_W = 14;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic trans_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_mtx_hold_reg.sv
// Enable-loaded holding register bank for one master port's address phase.
module ahb_mtx_hold_reg #(
  parameter int unsigned W = 8
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/ahb_mtx_in_stage.sv
// Matrix input stage: passes the master address phase through, or holds it
// while the output-stage arbiter has not yet accepted it.
module ahb_mtx_in_stage
  import ahb_mtx_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic              sel_op,
  output logic [ADDR_W-1:0] addr_op,
  output logic [1:0]        trans_op,
  output logic              write_op,
  output logic [2:0]        size_op,
  output logic [2:0]        burst_op,
  output logic [3:0]        prot_op,
  output logic              mastlock_op,
  output logic              held_tran_op,
  input  logic              addr_accept,
  input  logic              readyout_data,
  input  logic              resp_data
);

  localparam int unsigned HOLD_W = ADDR_W + ATTR_W;

  in_state_e         state_q, state_d;
  logic              trans_valid;
  logic              pend_tran;
  logic              data_phase;
  logic [HOLD_W-1:0] hold_d, hold_q;

  logic [ADDR_W-1:0] reg_addr;
  logic [1:0]        reg_trans;
  logic              reg_write;
  logic [2:0]        reg_size;
  logic [2:0]        reg_burst;
  logic [3:0]        reg_prot;
  logic              reg_lock;

  assign trans_valid = HSELS & HREADYS & trans_active(HTRANSS);
  assign pend_tran   = (state_q == IN_PEND);

  assign hold_d = {HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
  assign {reg_addr, reg_trans, reg_write, reg_size, reg_burst, reg_prot, reg_lock} = hold_q;

  ahb_mtx_hold_reg #(.W(HOLD_W)) u_hold (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .en      (trans_valid),
    .d       (hold_d),
    .q       (hold_q)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      state_q <= IN_IDLE;
    else
      state_q <= state_d;
  end

  // A transfer accepted in the same cycle it is offered never enters PEND.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IN_IDLE: if (trans_valid && !addr_accept) state_d = IN_PEND;
      IN_PEND: if (addr_accept)                 state_d = IN_IDLE;
      default: state_d = IN_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      data_phase <= 1'b0;
    else if (addr_accept)
      data_phase <= pend_tran | trans_valid;
    else if (readyout_data)
      data_phase <= 1'b0;
  end

  always_comb begin
    sel_op       = HSELS;
    addr_op      = HADDRS;
    trans_op     = HTRANSS;
    write_op     = HWRITES;
    size_op      = HSIZES;
    burst_op     = HBURSTS;
    prot_op      = HPROTS;
    mastlock_op  = HMASTLOCKS;
    held_tran_op = 1'b0;
    HREADYOUTS   = 1'b1;
    HRESPS       = 1'b0;
    if (pend_tran) begin
      sel_op       = 1'b1;
      addr_op      = reg_addr;
      trans_op     = reg_trans;
      write_op     = reg_write;
      size_op      = reg_size;
      burst_op     = reg_burst;
      prot_op      = reg_prot;
      mastlock_op  = reg_lock;
      held_tran_op = 1'b1;
      HREADYOUTS   = 1'b0;
    end else if (data_phase) begin
      HREADYOUTS = readyout_data;
      HRESPS     = resp_data;
    end
  end

endmodule

// File: tb/tb_ahb_mtx_in_stage.sv
// Scoreboarded bench for ahb_mtx_in_stage: directed address-phase vectors.
module tb_ahb_mtx_in_stage;
  import ahb_mtx_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS;
  logic        addr_accept, readyout_data, resp_data;
  logic        HREADYOUTS, HRESPS, sel_op, write_op, mastlock_op, held_tran_op;
  logic [31:0] addr_op;
  logic [1:0]  trans_op;
  logic [2:0]  size_op, burst_op;
  logic [3:0]  prot_op;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic        lock;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 HCLK = ~HCLK;

  ahb_mtx_in_stage #(.ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_op(sel_op), .addr_op(addr_op),
    .trans_op(trans_op), .write_op(write_op), .size_op(size_op), .burst_op(burst_op),
    .prot_op(prot_op), .mastlock_op(mastlock_op), .held_tran_op(held_tran_op),
    .addr_accept(addr_accept), .readyout_data(readyout_data), .resp_data(resp_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transfers issued downstream are popped and checked against the stimulus order.
  always @(negedge HCLK) begin
    if (HRESETn && sel_op && trans_op[1] && addr_accept) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL issue_unexpected: got addr 0x%0h expected no transfer", addr_op);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_addr", addr_op, e.addr);
        chk("issue_write", {31'd0, write_op}, {31'd0, e.write});
        chk("issue_lock", {31'd0, mastlock_op}, {31'd0, e.lock});
      end
    end
  end

  task automatic cyc(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                     input logic w, input logic lk, input logic hr, input logic acc,
                     input logic rdy, input logic rsp);
    @(posedge HCLK);
    #1;
    HSELS = sel; HTRANSS = tr; HADDRS = a; HWRITES = w; HMASTLOCKS = lk;
    HREADYS = hr; addr_accept = acc; readyout_data = rdy; resp_data = rsp;
    @(negedge HCLK);
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic w, input logic lk);
    exp_t e;
    e.addr = a; e.write = w; e.lock = lk;
    return e;
  endfunction

  initial begin
    HRESETn = 1'b0; HSELS = 1'b0; HADDRS = '0; HTRANSS = HTRANS_IDLE; HWRITES = 1'b0;
    HSIZES = 3'd2; HBURSTS = HBURST_SINGLE; HPROTS = 4'h3; HMASTLOCKS = 1'b0;
    HREADYS = 1'b1; addr_accept = 1'b0; readyout_data = 1'b1; resp_data = 1'b0;
    #2;
    chk("rst_hreadyout", {31'd0, HREADYOUTS}, 32'd1);
    chk("rst_hresp", {31'd0, HRESPS}, 32'd0);
    chk("rst_held", {31'd0, held_tran_op}, 32'd0);
    chk("rst_sel", {31'd0, sel_op}, 32'd0);
    @(posedge HCLK); #1 HRESETn = 1'b1;

    // Accepted in the same cycle: no hold, straight to data phase
    exp_q.push_back(mk(32'h1000, 1'b0, 1'b0));
    cyc(1, HTRANS_NONSEQ, 32'h1000, 0, 0, 1, 1, 1, 0);
    chk("t1_held", {31'd0, held_tran_op}, 32'd0);
    chk("t1_addr", addr_op, 32'h1000);
    chk("t1_rdy_a", {31'd0, HREADYOUTS}, 32'd1);
    cyc(1, HTRANS_IDLE, 32'h0, 0, 0, 1, 0, 0, 0);
    chk("t1_rdy_wait", {31'd0, HREADYOUTS}, 32'd0);
    cyc(1, HTRANS_IDLE, 32'h0, 0, 0, 0, 0, 1, 0);
    chk("t1_rdy_done", {31'd0, HREADYOUTS}, 32'd1);

    // Write held for three cycles while the master address moves
    exp_q.push_back(mk(32'h2000, 1'b1, 1'b0));
    cyc(1, HTRANS_NONSEQ, 32'h2000, 1, 0, 1, 0, 1, 0);
    chk("t2_rdy_offer", {31'd0, HREADYOUTS}, 32'd1);
    chk("t2_held_offer", {31'd0, held_tran_op}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, HTRANS_NONSEQ, 32'h2004 + 32'(4 * i), 0, 0, 0, 0, 1, 0);
      chk("t2_rdy_pend", {31'd0, HREADYOUTS}, 32'd0);
      chk("t2_addr_pend", addr_op, 32'h2000);
      chk("t2_write_pend", {31'd0, write_op}, 32'd1);
      chk("t2_held_pend", {31'd0, held_tran_op}, 32'd1);
    end
    cyc(1, HTRANS_IDLE, 32'h2100, 0, 0, 0, 1, 1, 0);
    chk("t2_addr_rel", addr_op, 32'h2000);
    chk("t2_rdy_rel", {31'd0, HREADYOUTS}, 32'd0);
    cyc(1, HTRANS_IDLE, 32'h0, 0, 0, 1, 0, 1, 0);
    chk("t2_rdy_data", {31'd0, HREADYOUTS}, 32'd1);
    chk("t2_held_data", {31'd0, held_tran_op}, 32'd0);

    // INCR4 with accept alternating: each beat held once then released
    HBURSTS = HBURST_INCR4;
    for (int k = 0; k < 4; k++) begin
      logic [1:0]  tr;
      logic [31:0] a;
      tr = (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      a  = 32'h3000 + 32'(4 * k);
      exp_q.push_back(mk(a, 1'b0, 1'b0));
      cyc(1, tr, a, 0, 0, 1, 0, 1, 0);
      chk("t3_rdy_offer", {31'd0, HREADYOUTS}, 32'd1);
      cyc(1, tr, a, 0, 0, 0, 1, 1, 0);
      chk("t3_held", {31'd0, held_tran_op}, 32'd1);
      chk("t3_addr", addr_op, a);
      chk("t3_burst", {29'd0, burst_op}, {29'd0, HBURST_INCR4});
    end
    cyc(1, HTRANS_IDLE, 32'h0, 0, 0, 1, 0, 1, 0);
    chk("t3_rdy_end", {31'd0, HREADYOUTS}, 32'd1);
    HBURSTS = HBURST_SINGLE;

    // Two-cycle ERROR response passes straight through
    exp_q.push_back(mk(32'h4000, 1'b0, 1'b0));
    cyc(1, HTRANS_NONSEQ, 32'h4000, 0, 0, 1, 1, 1, 0);
    cyc(1, HTRANS_IDLE, 32'h0, 0, 0, 1, 0, 0, 1);
    chk("t4_resp1", {31'd0, HRESPS}, 32'd1);
    chk("t4_rdy1", {31'd0, HREADYOUTS}, 32'd0);
    cyc(1, HTRANS_IDLE, 32'h0, 0, 0, 0, 0, 1, 1);
    chk("t4_resp2", {31'd0, HRESPS}, 32'd1);
    chk("t4_rdy2", {31'd0, HREADYOUTS}, 32'd1);
    cyc(1, HTRANS_IDLE, 32'h0, 0, 0, 1, 0, 1, 1);
    chk("t4_resp_gated", {31'd0, HRESPS}, 32'd0);

    // Reset while holding: transfer must be dropped
    cyc(1, HTRANS_NONSEQ, 32'h5000, 0, 0, 1, 0, 1, 0);
    cyc(1, HTRANS_NONSEQ, 32'h5000, 0, 0, 0, 0, 1, 0);
    chk("t5_held_pre", {31'd0, held_tran_op}, 32'd1);
    @(posedge HCLK);
    #1 HRESETn = 1'b0; HTRANSS = HTRANS_IDLE; HREADYS = 1'b1;
    #1;
    chk("t5_rst_rdy", {31'd0, HREADYOUTS}, 32'd1);
    chk("t5_rst_held", {31'd0, held_tran_op}, 32'd0);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1, HTRANS_IDLE, 32'h0, 0, 0, 1, 1, 1, 0);
      chk("t5_post_held", {31'd0, held_tran_op}, 32'd0);
      chk("t5_post_rdy", {31'd0, HREADYOUTS}, 32'd1);
    end

    // Locked transfer keeps mastlock_op while held
    exp_q.push_back(mk(32'h6000, 1'b0, 1'b1));
    cyc(1, HTRANS_NONSEQ, 32'h6000, 0, 1, 1, 0, 1, 0);
    chk("t6_lock_offer", {31'd0, mastlock_op}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      cyc(1, HTRANS_NONSEQ, 32'h6010, 0, 0, 0, 0, 1, 0);
      chk("t6_lock_pend", {31'd0, mastlock_op}, 32'd1);
      chk("t6_addr_pend", addr_op, 32'h6000);
    end
    cyc(1, HTRANS_IDLE, 32'h0, 0, 0, 0, 1, 1, 0);
    chk("t6_lock_rel", {31'd0, mastlock_op}, 32'd1);
    cyc(1, HTRANS_IDLE, 32'h0, 0, 0, 1, 0, 1, 0);
    chk("t6_held_after", {31'd0, held_tran_op}, 32'd0);

    cyc(0, HTRANS_IDLE, 32'h0, 0, 0, 1, 0, 1, 0);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_mtx_in_stage.md
AHB_MTX_IN_STAGE -- requirements
Module: ahb_mtx_in_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have HCLK  in  1  clock; all state on posedge.
REQ-003 SHALL have HRESETn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have HSELS  in  1  slave-port select from master.
REQ-005 SHALL have HADDRS  in  ADDR_W  master address.
REQ-006 SHALL have HTRANSS  in  2  master transfer type.
REQ-007 SHALL have HWRITES/HSIZES/HBURSTS/HPROTS  in  1/3/3/4  master attributes.
REQ-008 SHALL have HMASTLOCKS  in  1  master lock.
REQ-009 SHALL have HREADYS  in  1  bus HREADY seen by master.
REQ-010 SHALL have HREADYOUTS  out  1  ready to master.
REQ-011 SHALL have HRESPS  out  1  response to master (1 = ERROR).
REQ-012 SHALL have sel_op/addr_op/trans_op  out  1/ADDR_W/2  address phase to decode/output stages.
REQ-013 SHALL have write_op/size_op/burst_op/prot_op/mastlock_op  out  1/3/3/4/1  attributes downstream.
REQ-014 SHALL have held_tran_op  out  1  high when outputs come from holding registers.
REQ-015 SHALL have addr_accept  in  1  output-stage arbiter granted this port and HREADYM high this cycle.
REQ-016 SHALL have readyout_data/resp_data  in  1/1  downstream data-phase HREADYOUT/HRESP.

Function
REQ-017 trans_valid SHALL be HSELS & HREADYS & HTRANSS[1] (NONSEQ or SEQ).
REQ-018 Holding registers (addr, trans, write, size, burst, prot, lock) SHALL load on every trans_valid cycle, otherwise hold.
REQ-019 pend_tran SHALL follow: IDLE->PEND when trans_valid & ~addr_accept; PEND->IDLE when addr_accept; else hold.
REQ-020 In PEND, all *_op outputs SHALL come from holding registers, sel_op=1, held_tran_op=1.
REQ-021 In IDLE, *_op SHALL pass live master inputs combinationally, sel_op=HSELS, held_tran_op=0; zero added latency.
REQ-022 data_phase register: on addr_accept, load (pend_tran | trans_valid); else clear when readyout_data=1; else hold.
REQ-023 HREADYOUTS SHALL be 0 in PEND; readyout_data when IDLE & data_phase; else 1.
REQ-024 HRESPS SHALL be resp_data when IDLE & data_phase; else 0; two-cycle ERROR passes through unchanged.
REQ-025 Simultaneous trans_valid & addr_accept in IDLE SHALL NOT enter PEND; transfer goes directly to data phase.
REQ-026 A held transfer SHALL be released in the exact addr_accept cycle; earliest master HREADYOUTS=1 is the next data-phase completion.
REQ-027 IDLE/BUSY on master with no pending transfer SHALL NOT load state or assert pend_tran.
REQ-028 mastlock_op SHALL remain at held value throughout PEND.

Reset
REQ-029 On HRESETn low: pend_tran=0, data_phase=0, holding registers=0; HREADYOUTS=1, HRESPS=0, held_tran_op=0.
REQ-030 Reset mid-PEND SHALL discard the held transfer; no replay after release.

Structure
REQ-031 HTRANS/HBURST encodings SHALL live in shared package ahb_mtx_pkg, with arbiter stages.
REQ-032 Holding register bank SHALL be sub-module ahb_mtx_hold_reg (enable-loaded, async-reset); control stays in top.

Verification
REQ-033 NONSEQ 0x1000 with addr_accept=1 same cycle -> no PEND, held_tran_op=0, HREADYOUTS follows readyout_data next cycle.
REQ-034 NONSEQ 0x2000 write, addr_accept=0 for 3 cycles -> HREADYOUTS=0 for 3 cycles, addr_op=0x2000 held while HADDRS changes, release on 4th.
REQ-035 INCR4 burst with addr_accept toggling each beat -> each beat presented once, in order, none lost or duplicated.
REQ-036 Downstream ERROR (resp_data=1, readyout_data 0 then 1) -> HRESPS=1 both cycles, HREADYOUTS 0 then 1.
REQ-037 HRESETn asserted mid-PEND -> HREADYOUTS=1, held_tran_op=0 immediately; no transfer issued after reset.
REQ-038 Locked NONSEQ held 2 cycles -> mastlock_op=1 every cycle until accepted.
